// File: rtl/inst_fetch_controller_if.sv
// Fetch controller bus: instruction memory port, redirect input, decode
// stream and status outputs. The master side is the fetch controller.
interface inst_fetch_controller_if #(
  parameter int ADDR_W = 64
);
  logic              fetch_en;
  logic [ADDR_W-1:0] Inst_Address;
  logic [31:0]       Instruction;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              align_err;
  logic [31:0]       fetch_count;

  modport master (
    input  fetch_en,
    output Inst_Address,
    input  Instruction,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output align_err,
    output fetch_count
  );

  modport slave (
    output fetch_en,
    input  Inst_Address,
    output Instruction,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  align_err,
    input  fetch_count
  );
endinterface

// File: rtl/inst_fetch_controller.sv
// Instruction fetch controller: owns the PC, reads one 32-bit word per cycle
// from a combinational instruction memory and queues {word, pc} in a 2-entry
// FIFO that feeds decode. The FIFO head lives in the out_inst/out_pc
// registers and a single second-entry register sits behind it. Redirects
// flush the FIFO and restart fetch; a misaligned redirect parks the block in
// ERROR until an aligned redirect arrives.
module inst_fetch_controller #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  inst_fetch_controller_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam logic [1:0] DEPTH_CNT = DEPTH[1:0];

  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic [31:0]       head_inst;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       second_inst;
  logic [ADDR_W-1:0] second_pc;
  logic [31:0]       fetch_count;
  logic              align_err;
  logic              push;
  logic              pop;
  logic              misaligned;

  assign bus.Inst_Address = pc;
  assign bus.out_valid    = (count != 2'd0);
  assign bus.out_inst     = head_inst;
  assign bus.out_pc       = head_pc;
  assign bus.align_err    = align_err;
  assign bus.fetch_count  = fetch_count;

  assign pop        = bus.out_valid & bus.out_ready;
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // A word is pushed only while fetching with room, where a same-cycle pop
  // frees room in a full FIFO; a redirect suppresses the push.
  always_comb begin
    push = 1'b0;
    if (!bus.redirect_valid && bus.fetch_en &&
        (state == FETCH || state == FULL) &&
        (count != DEPTH_CNT || pop)) begin
      push = 1'b1;
    end
  end

  // Occupancy for next cycle; a redirect flushes everything.
  always_comb begin
    count_next = count;
    if (bus.redirect_valid) begin
      count_next = 2'd0;
    end else begin
      count_next = count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Next-state decode with redirect taking priority over all other moves.
  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      if (misaligned) begin
        state_next = ERROR;
      end else if (bus.fetch_en) begin
        state_next = FETCH;
      end else begin
        state_next = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.fetch_en) state_next = FETCH;
        end
        FETCH: begin
          if (!bus.fetch_en) begin
            state_next = IDLE;
          end else if (count_next == DEPTH_CNT) begin
            state_next = FULL;
          end
        end
        FULL: begin
          if (pop) state_next = FETCH;
        end
        ERROR: begin
          state_next = ERROR;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control registers: PC, state, occupancy, alignment flag and pop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      state       <= IDLE;
      count       <= 2'd0;
      align_err   <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (bus.redirect_valid) begin
        pc        <= bus.redirect_pc;
        align_err <= misaligned;
      end else if (push) begin
        pc <= pc + ADDR_W'(4);
      end
    end
  end

  // FIFO data: the head register feeds decode directly, the second register
  // holds the next word and shifts forward when the head is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_inst   <= 32'd0;
      head_pc     <= '0;
      second_inst <= 32'd0;
      second_pc   <= '0;
    end else if (!bus.redirect_valid) begin
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        head_inst <= bus.Instruction;
        head_pc   <= pc;
      end else if (pop && count == 2'd2) begin
        head_inst <= second_inst;
        head_pc   <= second_pc;
      end
      if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) begin
        second_inst <= bus.Instruction;
        second_pc   <= pc;
      end
    end
  end

endmodule
